// File: rtl/ov7670_capture_gray.sv
// OV7670 RGB565 capture into an 8-bit grayscale frame buffer.
// Only whole frames are stored; writes land at line*width + column.
module ov7670_capture_gray #(
    parameter int width  = 640,
    parameter int height = 480
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        vsync,
    input  logic        href,
    input  logic [7:0]  d,
    output logic [18:0] addr,
    output logic [7:0]  dout,
    output logic        we,
    output logic        frame_done,
    output logic [7:0]  frame_cnt,
    output logic        err_overrun,
    output logic        err_odd
);

    localparam int CW = $clog2(width + 1);
    localparam int LW = $clog2(height + 1);
    localparam logic [CW-1:0] COL_MAX  = CW'(width);
    localparam logic [LW-1:0] LINE_MAX = LW'(height);

    localparam logic [1:0] SYNC  = 2'd0;
    localparam logic [1:0] FRAME = 2'd1;
    localparam logic [1:0] LINE  = 2'd2;

    logic [1:0]    rst_sync;
    logic          rst_int_n;
    logic [1:0]    state;
    logic          seen_vs;
    logic [CW-1:0] col;
    logic [LW-1:0] line_cnt;
    logic          phase;
    logic [7:0]    hi_p0;
    logic [15:0]   pix;

    function automatic logic [7:0] luma(input logic [15:0] px);
        logic [7:0]  r8;
        logic [7:0]  g8;
        logic [7:0]  b8;
        logic [15:0] acc;
        r8  = {px[15:11], px[15:13]};
        g8  = {px[10:5], px[10:9]};
        b8  = {px[4:0], px[4:2]};
        acc = 16'd77 * {8'd0, r8} + 16'd150 * {8'd0, g8} + 16'd29 * {8'd0, b8};
        return acc[15:8];
    endfunction

    // Assert asynchronously, release on a pclk edge.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    assign pix = {hi_p0, d};

    always_ff @(posedge pclk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state       <= SYNC;
            seen_vs     <= 1'b0;
            col         <= '0;
            line_cnt    <= '0;
            phase       <= 1'b0;
            hi_p0       <= 8'd0;
            addr        <= 19'd0;
            dout        <= 8'd0;
            we          <= 1'b0;
            frame_done  <= 1'b0;
            frame_cnt   <= 8'd0;
            err_overrun <= 1'b0;
            err_odd     <= 1'b0;
        end else begin
            we         <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                SYNC: begin
                    if (vsync) begin
                        seen_vs <= 1'b1;
                    end else if (seen_vs) begin
                        state       <= FRAME;
                        seen_vs     <= 1'b0;
                        col         <= '0;
                        line_cnt    <= '0;
                        phase       <= 1'b0;
                        err_overrun <= 1'b0;
                        err_odd     <= 1'b0;
                    end
                end
                FRAME: begin
                    if (vsync) begin
                        // vsync is already high here, so the next falling edge starts a frame
                        state      <= SYNC;
                        seen_vs    <= 1'b1;
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 8'd1;
                    end else if (href) begin
                        state <= LINE;
                        hi_p0 <= d;
                        phase <= 1'b1;
                    end
                end
                LINE: begin
                    if (vsync) begin
                        state      <= SYNC;
                        seen_vs    <= 1'b1;
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 8'd1;
                        col        <= '0;
                        phase      <= 1'b0;
                    end else if (!href) begin
                        state <= FRAME;
                        col   <= '0;
                        phase <= 1'b0;
                        if (phase) err_odd <= 1'b1;
                        if (line_cnt != LINE_MAX) line_cnt <= line_cnt + LW'(1);
                    end else if (!phase) begin
                        hi_p0 <= d;
                        phase <= 1'b1;
                    end else begin
                        phase <= 1'b0;
                        if (col < COL_MAX && line_cnt < LINE_MAX) begin
                            we   <= 1'b1;
                            addr <= 19'(line_cnt) * 19'(width) + 19'(col);
                            dout <= luma(pix);
                        end else begin
                            err_overrun <= 1'b1;
                        end
                        if (col != COL_MAX) col <= col + CW'(1);
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_capture_gray.sv
// Directed bench for ov7670_capture_gray: default 640x480 instance plus a 4x2
// instance sharing the same camera stimulus.
module tb_ov7670_capture_gray;

    logic        pclk;
    logic        rst_n;
    logic        vsync;
    logic        href;
    logic [7:0]  d;

    logic [18:0] addr,        addr_s;
    logic [7:0]  dout,        dout_s;
    logic        we,          we_s;
    logic        frame_done,  frame_done_s;
    logic [7:0]  frame_cnt,   frame_cnt_s;
    logic        err_overrun, err_overrun_s;
    logic        err_odd,     err_odd_s;

    int compared;
    int mismatched;

    ov7670_capture_gray dut (
        .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href), .d(d),
        .addr(addr), .dout(dout), .we(we), .frame_done(frame_done),
        .frame_cnt(frame_cnt), .err_overrun(err_overrun), .err_odd(err_odd)
    );

    ov7670_capture_gray #(.width(4), .height(2)) dut_s (
        .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href), .d(d),
        .addr(addr_s), .dout(dout_s), .we(we_s), .frame_done(frame_done_s),
        .frame_cnt(frame_cnt_s), .err_overrun(err_overrun_s), .err_odd(err_odd_s)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        logic        vs;
        logic        hr;
        logic [7:0]  dd;
        logic        we;
        logic [18:0] addr;
        logic [7:0]  dout;
        logic        fd;
        logic [7:0]  fcnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic vs, input logic hr, input logic [7:0] dd, input logic w,
                       input int a, input int dt, input logic fd, input int fc);
        vec_t v;
        v.vs = vs; v.hr = hr; v.dd = dd; v.we = w;
        v.addr = 19'(a); v.dout = 8'(dt); v.fd = fd; v.fcnt = 8'(fc);
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input logic vs, input logic hr, input logic [7:0] dd);
        vsync = vs;
        href  = hr;
        d     = dd;
        @(posedge pclk);
        #1;
    endtask

    task automatic pixel(input logic [15:0] px);
        step(1'b0, 1'b1, px[15:8]);
        step(1'b0, 1'b1, px[7:0]);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n = 1'b0;
        vsync = 1'b0;
        href  = 1'b0;
        d     = 8'd0;

        // Main frame: line 0 = FFFF,0000; line 1 = 1234; line 2 = 0000; line 3 = F800,07E0,001F
        add(1,0,8'h00, 0,   0,  0, 0,0);
        add(1,0,8'h00, 0,   0,  0, 0,0);
        add(0,0,8'h00, 0,   0,  0, 0,0);
        add(0,1,8'hFF, 0,   0,  0, 0,0);
        add(0,1,8'hFF, 1,   0,255, 0,0);
        add(0,1,8'h00, 0,   0,255, 0,0);
        add(0,1,8'h00, 1,   1,  0, 0,0);
        add(0,0,8'h00, 0,   1,  0, 0,0);
        add(0,1,8'h12, 0,   1,  0, 0,0);
        add(0,1,8'h34, 1, 640, 63, 0,0);
        add(0,0,8'h00, 0, 640, 63, 0,0);
        add(0,1,8'h00, 0, 640, 63, 0,0);
        add(0,1,8'h00, 1,1280,  0, 0,0);
        add(0,0,8'h00, 0,1280,  0, 0,0);
        add(0,1,8'hF8, 0,1280,  0, 0,0);
        add(0,1,8'h00, 1,1920, 76, 0,0);
        add(0,1,8'h07, 0,1920, 76, 0,0);
        add(0,1,8'hE0, 1,1921,149, 0,0);
        add(0,1,8'h00, 0,1921,149, 0,0);
        add(0,1,8'h1F, 1,1922, 28, 0,0);
        add(0,0,8'h00, 0,1922, 28, 0,0);
        add(1,0,8'h00, 0,1922, 28, 1,1);
        add(1,0,8'h00, 0,1922, 28, 0,1);

        // Reset state
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk("rst.addr",  32'(addr), 0);
        chk("rst.dout",  32'(dout), 0);
        chk("rst.we",    32'(we), 0);
        chk("rst.fd",    32'(frame_done), 0);
        chk("rst.fcnt",  32'(frame_cnt), 0);
        chk("rst.ovr",   32'(err_overrun), 0);
        chk("rst.odd",   32'(err_odd), 0);
        chk("rst.we_s",  32'(we_s), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);

        // No vsync high seen yet: line activity must not be stored
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 8'hFF);
            chk($sformatf("presync.we%0d", i), 32'(we), 0);
        end
        step(1'b0, 1'b0, 8'h00);

        foreach (tbl[i]) begin
            step(tbl[i].vs, tbl[i].hr, tbl[i].dd);
            chk($sformatf("tbl%0d.we", i),   32'(we),         32'(tbl[i].we));
            chk($sformatf("tbl%0d.addr", i), 32'(addr),       32'(tbl[i].addr));
            chk($sformatf("tbl%0d.dout", i), 32'(dout),       32'(tbl[i].dout));
            chk($sformatf("tbl%0d.fd", i),   32'(frame_done), 32'(tbl[i].fd));
            chk($sformatf("tbl%0d.fcnt", i), 32'(frame_cnt),  32'(tbl[i].fcnt));
        end

        // Overrun on the 4x2 instance
        step(1'b0, 1'b0, 8'h00);
        chk("ovr.clear_s", 32'(err_overrun_s), 0);
        for (int k = 0; k < 6; k++) begin
            pixel(16'hFFFF);
            chk($sformatf("ovr.we_s%0d", k), 32'(we_s), (k < 4) ? 1 : 0);
            if (k < 4) begin
                chk($sformatf("ovr.addr_s%0d", k), 32'(addr_s), 32'(k));
                chk($sformatf("ovr.dout_s%0d", k), 32'(dout_s), 255);
            end
            chk($sformatf("ovr.addr%0d", k), 32'(addr), 32'(k));
        end
        chk("ovr.flag_s", 32'(err_overrun_s), 1);
        chk("ovr.flag",   32'(err_overrun), 0);
        step(1'b0, 1'b0, 8'h00);
        pixel(16'hFFFF);
        chk("ovr.l1_we_s",   32'(we_s), 1);
        chk("ovr.l1_addr_s", 32'(addr_s), 4);
        step(1'b0, 1'b0, 8'h00);
        pixel(16'hFFFF);
        chk("ovr.l2_we_s", 32'(we_s), 0);
        chk("ovr.l2_we",   32'(we), 1);
        step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        chk("ovr.fd_s",     32'(frame_done_s), 1);
        chk("ovr.hold_s",   32'(err_overrun_s), 1);
        chk("ovr.fcnt",     32'(frame_cnt), 2);
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk("ovr.cleared_s", 32'(err_overrun_s), 0);

        // Odd byte count on a line
        pixel(16'hFFFF);
        chk("odd.we",   32'(we), 1);
        chk("odd.addr", 32'(addr), 0);
        step(1'b0, 1'b1, 8'h12);
        chk("odd.we_lone", 32'(we), 0);
        step(1'b0, 1'b0, 8'h00);
        chk("odd.flag",   32'(err_odd), 1);
        chk("odd.we_end", 32'(we), 0);
        pixel(16'h0000);
        chk("odd.l1_we",   32'(we), 1);
        chk("odd.l1_addr", 32'(addr), 640);
        chk("odd.l1_dout", 32'(dout), 0);
        step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        chk("odd.fd",   32'(frame_done), 1);
        chk("odd.hold", 32'(err_odd), 1);
        chk("odd.fcnt", 32'(frame_cnt), 3);
        step(1'b0, 1'b0, 8'h00);
        chk("odd.cleared", 32'(err_odd), 0);

        // Reset in the middle of a line
        pixel(16'hFFFF);
        pixel(16'hFFFF);
        chk("mid.we",   32'(we), 1);
        chk("mid.addr", 32'(addr), 1);
        step(1'b0, 1'b1, 8'hAA);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid.async_we",   32'(we), 0);
        chk("mid.async_addr", 32'(addr), 0);
        chk("mid.async_dout", 32'(dout), 0);
        chk("mid.async_fcnt", 32'(frame_cnt), 0);
        chk("mid.async_fd",   32'(frame_done), 0);
        @(posedge pclk);
        #1;
        step(1'b0, 1'b1, 8'hBB);
        chk("mid.held_we", 32'(we), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);
        pixel(16'hFFFF);
        chk("mid.nosync_we", 32'(we), 0);
        step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        chk("mid.sync_fd", 32'(frame_done), 0);
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        pixel(16'hFFFF);
        chk("mid.cap_we",   32'(we), 1);
        chk("mid.cap_addr", 32'(addr), 0);
        chk("mid.cap_dout", 32'(dout), 255);
        step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        chk("mid.cap_fd",   32'(frame_done), 1);
        chk("mid.cap_fcnt", 32'(frame_cnt), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
